// File: rtl/seq_pattern_generator_pkg.sv
// seq_pkg: shared types and constants for the serial sequence transmitter
// and the detectors that consume its output.
//   state_e      - transmitter FSM states
//   MAX_LEN_DEF  - default maximum pattern length
//   CNT_W_DEF    - default repeat/gap counter width
//   SEQ_110      - canonical "110" pattern (length SEQ_110_LEN)
package seq_pkg;

    localparam int MAX_LEN_DEF = 8;
    localparam int CNT_W_DEF   = 8;

    localparam logic [2:0] SEQ_110     = 3'b110;
    localparam int         SEQ_110_LEN = 3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    // A pattern length is usable when it selects at least one bit and no
    // more than the register holds.
    function automatic logic len_legal(input int len, input int max_len);
        return (len >= 1) && (len <= max_len);
    endfunction

endpackage

// File: rtl/seq_pattern_generator_if.sv
// seq_pattern_generator_if: control and serial output bundle of the
// pattern transmitter.
//   master - stimulus side: drives start/abort/pattern config, reads outputs
//   slave  - transmitter side
// Control: start, abort, pattern[MAX_LEN], pat_len[LEN_W],
//          repeat_cnt[CNT_W], gap_cycles[CNT_W]
// Output:  seq_out, seq_valid, pat_first, busy, done, err
interface seq_pattern_generator_if #(
    parameter int MAX_LEN = seq_pkg::MAX_LEN_DEF,
    parameter int CNT_W   = seq_pkg::CNT_W_DEF
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    logic               start;
    logic               abort;
    logic [MAX_LEN-1:0] pattern;
    logic [LEN_W-1:0]   pat_len;
    logic [CNT_W-1:0]   repeat_cnt;
    logic [CNT_W-1:0]   gap_cycles;

    logic               seq_out;
    logic               seq_valid;
    logic               pat_first;
    logic               busy;
    logic               done;
    logic               err;

    modport master (
        output start, abort, pattern, pat_len, repeat_cnt, gap_cycles,
        input  seq_out, seq_valid, pat_first, busy, done, err
    );

    modport slave (
        input  start, abort, pattern, pat_len, repeat_cnt, gap_cycles,
        output seq_out, seq_valid, pat_first, busy, done, err
    );

endinterface

// File: rtl/seq_pattern_shreg.sv
// seq_pattern_shreg: parallel-load shift register holding the pattern
// being transmitted. On load the active bits are moved up so that bit
// load_len-1 lands in the MSB; each shift moves the next bit into the MSB.
//   clk, rst  - clock, async active-high reset
//   load      - capture load_pat aligned to load_len (wins over shift)
//   shift     - shift left by one
//   load_pat  - pattern bits, active bits in [load_len-1:0]
//   load_len  - pattern length (1..MAX_LEN)
//   msb       - current bit to transmit
module seq_pattern_shreg
    import seq_pkg::*;
#(
    parameter  int MAX_LEN = MAX_LEN_DEF,
    localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               shift,
    input  logic [MAX_LEN-1:0] load_pat,
    input  logic [LEN_W-1:0]   load_len,
    output logic               msb
);

    localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);

    logic [MAX_LEN-1:0] sh_q, sh_d;
    logic [LEN_W-1:0]   shamt;

    always_comb begin
        shamt = MAX_L - load_len;
        sh_d  = sh_q;
        if (load)
            sh_d = load_pat << shamt;
        else if (shift)
            sh_d = {sh_q[MAX_LEN-2:0], 1'b0};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sh_q <= '0;
        else     sh_q <= sh_d;
    end

    assign msb = sh_q[MAX_LEN-1];

endmodule

// File: rtl/seq_pattern_generator.sv
// seq_pattern_generator: bit-serial pattern transmitter. Once started it
// sends the latched pattern MSB-first, repeat_cnt times (0 = forever),
// with gap_cycles idle cycles between instances.
//   clk, rst - clock, async active-high reset
//   bus      - slave side of seq_pattern_generator_if (control in,
//              seq_out/seq_valid/pat_first/busy/done/err out)
// All outputs are flops. They describe the state the FSM was in during
// the previous cycle, which gives the one-cycle start-to-first-bit latency.
module seq_pattern_generator
    import seq_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    seq_pattern_generator_if.slave  bus
);

    localparam int LEN_W = $clog2(MAX_LEN + 1);

    state_e             state_q, state_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   rep_q, rep_d;       // remaining instances, 0 = continuous
    logic [CNT_W-1:0]   gap_q, gap_d;       // latched gap length
    logic [CNT_W-1:0]   gap_cnt_q, gap_cnt_d;

    logic seq_out_q, seq_out_d;
    logic seq_valid_q, seq_valid_d;
    logic pat_first_q, pat_first_d;
    logic busy_q, busy_d;
    logic done_q, done_d;
    logic err_q, err_d;

    logic               sh_load, sh_shift, sh_msb;
    logic [MAX_LEN-1:0] sh_pat;
    logic [LEN_W-1:0]   sh_len;

    seq_pattern_shreg #(.MAX_LEN(MAX_LEN)) u_shreg (
        .clk      (clk),
        .rst      (rst),
        .load     (sh_load),
        .shift    (sh_shift),
        .load_pat (sh_pat),
        .load_len (sh_len),
        .msb      (sh_msb)
    );

    always_comb begin
        state_d     = state_q;
        pat_d       = pat_q;
        len_d       = len_q;
        idx_d       = idx_q;
        rep_d       = rep_q;
        gap_d       = gap_q;
        gap_cnt_d   = gap_cnt_q;
        seq_out_d   = 1'b0;
        seq_valid_d = 1'b0;
        pat_first_d = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        sh_load     = 1'b0;
        sh_shift    = 1'b0;
        sh_pat      = pat_q;
        sh_len      = len_q;

        if (bus.abort && state_q != S_IDLE) begin
            // Outputs already defaulted to 0 for the cycle after abort.
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    // abort in IDLE suppresses both start and err.
                    if (bus.start && !bus.abort) begin
                        if (len_legal(int'(bus.pat_len), MAX_LEN)) begin
                            state_d = S_SEND;
                            pat_d   = bus.pattern;
                            len_d   = bus.pat_len;
                            rep_d   = bus.repeat_cnt;
                            gap_d   = bus.gap_cycles;
                            idx_d   = bus.pat_len - 1'b1;
                            sh_load = 1'b1;
                            sh_pat  = bus.pattern;
                            sh_len  = bus.pat_len;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end

                S_SEND: begin
                    seq_valid_d = 1'b1;
                    seq_out_d   = sh_msb;
                    pat_first_d = (idx_q == len_q - 1'b1);
                    busy_d      = 1'b1;
                    sh_shift    = 1'b1;
                    if (idx_q == '0) begin
                        // Reload now so the next instance (after a gap or
                        // back-to-back) starts from its first bit.
                        sh_load = 1'b1;
                        idx_d   = len_q - 1'b1;
                        if (rep_q == CNT_W'(1)) begin
                            rep_d   = '0;
                            state_d = S_DONE;
                        end else begin
                            if (rep_q != '0)
                                rep_d = rep_q - 1'b1;
                            if (gap_q != '0) begin
                                gap_cnt_d = gap_q;
                                state_d   = S_GAP;
                            end
                        end
                    end else begin
                        idx_d = idx_q - 1'b1;
                    end
                end

                S_GAP: begin
                    busy_d = 1'b1;
                    if (gap_cnt_q <= CNT_W'(1)) begin
                        gap_cnt_d = '0;
                        state_d   = S_SEND;
                    end else begin
                        gap_cnt_d = gap_cnt_q - 1'b1;
                    end
                end

                S_DONE: begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end

                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pat_q       <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            rep_q       <= '0;
            gap_q       <= '0;
            gap_cnt_q   <= '0;
            seq_out_q   <= 1'b0;
            seq_valid_q <= 1'b0;
            pat_first_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pat_q       <= pat_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            rep_q       <= rep_d;
            gap_q       <= gap_d;
            gap_cnt_q   <= gap_cnt_d;
            seq_out_q   <= seq_out_d;
            seq_valid_q <= seq_valid_d;
            pat_first_q <= pat_first_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign bus.seq_out   = seq_out_q;
    assign bus.seq_valid = seq_valid_q;
    assign bus.pat_first = pat_first_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_seq_pattern_generator.sv
// Directed bench for seq_pattern_generator. Output vectors are packed as
// {seq_out, seq_valid, pat_first, busy, done, err}.
module tb_seq_pattern_generator;
    import seq_pkg::*;

    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 8;

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    seq_pattern_generator_if #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) bus ();

    seq_pattern_generator #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    localparam logic [5:0] IDLE_V = 6'b000000;
    localparam logic [5:0] GAP_V  = 6'b000100;
    localparam logic [5:0] DONE_V = 6'b000010;
    localparam logic [5:0] ERR_V  = 6'b000001;

    function automatic logic [5:0] outs();
        return {bus.seq_out, bus.seq_valid, bus.pat_first, bus.busy, bus.done, bus.err};
    endfunction

    function automatic logic [5:0] bitv(input logic b, input logic first);
        return {b, 1'b1, first, 1'b1, 2'b00};
    endfunction

    task automatic chk(input string tag, input logic [5:0] exp);
        total++;
        assert (outs() === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, outs(), exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Called at a negedge; returns at the next negedge with start sampled.
    task automatic go(input logic [7:0] p, input logic [3:0] l,
                      input logic [7:0] r, input logic [7:0] g);
        bus.pattern    = p;
        bus.pat_len    = l;
        bus.repeat_cnt = r;
        bus.gap_cycles = g;
        bus.start      = 1'b1;
        tick();
        bus.start      = 1'b0;
    endtask

    initial begin
        logic [7:0] p110;
        logic [7:0] pat8;
        p110 = 8'(SEQ_110);

        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.abort      = 1'b0;
        bus.pattern    = '0;
        bus.pat_len    = '0;
        bus.repeat_cnt = '0;
        bus.gap_cycles = '0;
        #12;
        chk("reset", IDLE_V);
        tick();
        rst = 1'b0;

        // Single instance of 110
        go(p110, 4'd3, 8'd1, 8'd0);
        chk("s1_lat", IDLE_V);
        tick(); chk("s1_b0", bitv(1'b1, 1'b1));
        tick(); chk("s1_b1", bitv(1'b1, 1'b0));
        tick(); chk("s1_b2", bitv(1'b0, 1'b0));
        tick(); chk("s1_done", DONE_V);
        tick(); chk("s1_idle", IDLE_V);

        // Two instances separated by a 2-cycle gap
        go(p110, 4'd3, 8'd2, 8'd2);
        chk("rg_lat", IDLE_V);
        tick(); chk("rg_a0", bitv(1'b1, 1'b1));
        tick(); chk("rg_a1", bitv(1'b1, 1'b0));
        tick(); chk("rg_a2", bitv(1'b0, 1'b0));
        tick(); chk("rg_g0", GAP_V);
        tick(); chk("rg_g1", GAP_V);
        tick(); chk("rg_b0", bitv(1'b1, 1'b1));
        tick(); chk("rg_b1", bitv(1'b1, 1'b0));
        tick(); chk("rg_b2", bitv(1'b0, 1'b0));
        tick(); chk("rg_done", DONE_V);
        tick(); chk("rg_idle", IDLE_V);

        // Continuous back-to-back run, then abort
        go(p110, 4'd3, 8'd0, 8'd0);
        chk("ct_lat", IDLE_V);
        for (int i = 0; i < 24; i++) begin
            tick();
            chk($sformatf("ct_%0d", i), bitv((i % 3) != 2, (i % 3) == 0));
        end
        bus.abort = 1'b1;
        tick(); chk("ct_abort", IDLE_V);
        bus.abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(); chk($sformatf("ct_post_%0d", i), IDLE_V);
        end

        // Illegal lengths
        go(p110, 4'd0, 8'd1, 8'd0);
        chk("il0_err", ERR_V);
        tick(); chk("il0_after", IDLE_V);
        go(p110, 4'(MAX_LEN + 1), 8'd1, 8'd0);
        chk("il9_err", ERR_V);
        tick(); chk("il9_after", IDLE_V);

        // abort beats start in IDLE (illegal and legal length)
        bus.abort = 1'b1;
        go(p110, 4'd0, 8'd1, 8'd0);
        chk("ab_noerr", IDLE_V);
        go(p110, 4'd3, 8'd1, 8'd0);
        chk("ab_nostart0", IDLE_V);
        bus.abort = 1'b0;
        tick(); chk("ab_nostart1", IDLE_V);

        // start while busy with new config is ignored; latched values used
        go(p110, 4'd3, 8'd1, 8'd0);
        chk("bp_lat", IDLE_V);
        tick(); chk("bp_b0", bitv(1'b1, 1'b1));
        bus.pattern = 8'hFF;
        bus.pat_len = 4'd0;
        bus.start   = 1'b1;
        tick(); chk("bp_b1", bitv(1'b1, 1'b0));
        bus.pat_len = 4'd5;
        tick(); chk("bp_b2", bitv(1'b0, 1'b0));
        bus.start = 1'b0;
        tick(); chk("bp_done", DONE_V);
        tick(); chk("bp_idle", IDLE_V);

        // Bits above pat_len are ignored: 0xFA, len 3 -> 0,1,0
        go(8'hFA, 4'd3, 8'd1, 8'd0);
        chk("mk_lat", IDLE_V);
        tick(); chk("mk_b0", bitv(1'b0, 1'b1));
        tick(); chk("mk_b1", bitv(1'b1, 1'b0));
        tick(); chk("mk_b2", bitv(1'b0, 1'b0));
        tick(); chk("mk_done", DONE_V);

        // Full-width pattern
        pat8 = 8'hA3;
        tick();
        go(pat8, 4'(MAX_LEN), 8'd1, 8'd0);
        chk("f8_lat", IDLE_V);
        for (int i = 0; i < MAX_LEN; i++) begin
            tick();
            chk($sformatf("f8_%0d", i), bitv(pat8[MAX_LEN-1-i], i == 0));
        end
        tick(); chk("f8_done", DONE_V);

        // pat_len=1: every valid bit is a first bit; gap of 1
        tick();
        go(8'h01, 4'd1, 8'd3, 8'd1);
        chk("l1_lat", IDLE_V);
        tick(); chk("l1_a", bitv(1'b1, 1'b1));
        tick(); chk("l1_g0", GAP_V);
        tick(); chk("l1_b", bitv(1'b1, 1'b1));
        tick(); chk("l1_g1", GAP_V);
        tick(); chk("l1_c", bitv(1'b1, 1'b1));
        tick(); chk("l1_done", DONE_V);

        // Async reset during the second bit
        tick();
        go(p110, 4'd3, 8'd1, 8'd0);
        chk("rs_lat", IDLE_V);
        tick(); chk("rs_b0", bitv(1'b1, 1'b1));
        @(posedge clk);
        #1;
        chk("rs_b1", bitv(1'b1, 1'b0));
        #1;
        rst = 1'b1;
        #1;
        chk("rs_async", IDLE_V);
        tick();
        rst = 1'b0;
        tick(); chk("rs_nodone", IDLE_V);
        go(p110, 4'd3, 8'd1, 8'd0);
        chk("rs2_lat", IDLE_V);
        tick(); chk("rs2_b0", bitv(1'b1, 1'b1));
        tick(); chk("rs2_b1", bitv(1'b1, 1'b0));
        tick(); chk("rs2_b2", bitv(1'b0, 1'b0));
        tick(); chk("rs2_done", DONE_V);
        tick(); chk("rs2_idle", IDLE_V);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute backstop so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/seq_pattern_generator.md
Name: seq_pattern_generator

Overview:
Bit-serial pattern transmitter that drives a serial sequence line for downstream sequence detectors, including the "110" detector. It is loaded with a pattern of up to MAX_LEN bits, a length, a repeat count and an inter-pattern gap. It then emits the pattern MSB-first, one bit per clock, with a valid qualifier. It is the stimulus/transmit end of the serial sequence interface and sits upstream of detector blocks, on-chip or in self-test.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (>=2)
CNT_W, 8, width of the repeat and gap counters
LEN_W, $clog2(MAX_LEN+1), width of pat_len (derived; not overridden)

Ports:
clk  input  1  rising-edge clock (only clock)
rst  input  1  asynchronous, active-high reset
start  input  1  begin transmission; sampled only in IDLE
abort  input  1  stop transmission; return to IDLE
pattern  input  MAX_LEN  pattern bits; the active bits are pattern[pat_len-1:0], sent from bit pat_len-1 down to bit 0
pat_len  input  LEN_W  pattern length; legal range 1..MAX_LEN
repeat_cnt  input  CNT_W  number of pattern instances; 0 means continuous until abort
gap_cycles  input  CNT_W  idle cycles inserted between instances; 0 means back-to-back
seq_out  output  1  serial data bit (registered)
seq_valid  output  1  seq_out carries a pattern bit (registered)
pat_first  output  1  high with the first bit of each instance
busy  output  1  high in SEND and GAP
done  output  1  one-cycle pulse after the final bit of a finite run
err  output  1  one-cycle pulse when start is given with an illegal pat_len

Behaviour:
- Reset (asynchronous, rst=1):
  - State goes to IDLE.
  - seq_out, seq_valid, pat_first, busy, done and err are all 0.
  - All internal registers are cleared.
  - Reset asserted mid-transmission truncates the transmission immediately; there is no done pulse.
- All outputs are registered. No combinational path exists from any input to any output.
- States:
  - IDLE: outputs 0. If start=1 and 1<=pat_len<=MAX_LEN: latch pattern, pat_len, repeat_cnt and gap_cycles, then go to SEND. If start=1 and pat_len is 0 or >MAX_LEN: pulse err for 1 cycle and stay in IDLE.
  - SEND: seq_valid=1 and seq_out=current bit. pat_first=1 on bit index pat_len-1. Decrement the bit index each cycle.
  - After the last bit (index 0) of an instance:
    - finite run with the remaining repeats now 0: go to DONE;
    - else, if gap>0: go to GAP;
    - else: reload the bit index and stay in SEND, so the next instance's first bit follows with no bubble.
  - GAP: seq_valid=0, seq_out=0, busy=1. Hold for exactly gap_cycles cycles, then go to SEND.
  - DONE: done=1 and busy=0 for one cycle, then go to IDLE unconditionally.
- Latency: with start sampled at rising edge k, the first bit is valid in the cycle after edge k+1 (one-cycle latency). A run of n bits, r repeats and gap g occupies exactly r*n + (r-1)*g cycles from the first bit to the last bit.
- Latched inputs: the block uses only the values captured at start. Input changes while busy have no effect.
- start while busy (SEND/GAP/DONE) is ignored, with no err.
- abort=1 in any non-IDLE state: the next state is IDLE, all outputs are 0 on the following cycle, and there is no done pulse. In IDLE, abort wins over a simultaneous start: no transmission and no err.
- repeat_cnt=0 gives continuous mode: it never reaches DONE, and the repeat counter does not decrement or wrap.
- pat_len=1: every cycle of an instance is the first bit, so pat_first=1 whenever seq_valid=1.

Decomposition:
- Shared package seq_pkg:
  - state enum/constants S_IDLE, S_SEND, S_GAP, S_DONE;
  - MAX_LEN default;
  - the canonical "110" pattern constant SEQ_110 = 3'b110 with length 3, shared with the detector.
- One natural sub-module: seq_pattern_shreg, a MAX_LEN-bit parallel-load register that is MSB-aligned on load to pat_len and shifts left each SEND cycle. It reloads from the latched pattern at the start of each instance.
- The FSM, the repeat counter and the gap counter stay in the top module.

Test Plan:
- Single instance: pattern=...110, pat_len=3, repeat=1, gap=0, start one cycle → seq_out=1,1,0 on 3 consecutive seq_valid cycles; pat_first on the first; done pulses on the next cycle; busy is high for exactly 3 cycles.
- Repeat with gap: same pattern, repeat=2, gap=2 → valid stream 1,1,0, then 2 cycles of seq_valid=0, then 1,1,0, then done. Total busy time is 8 cycles.
- Continuous and abort: repeat=0, gap=0, pattern 110 → the 1,1,0 stream runs back-to-back for more than 20 cycles with no done. Asserting abort gives seq_valid=0 and busy=0 on the next cycle, and no done.
- Illegal length: start with pat_len=0, then with pat_len=MAX_LEN+1 → one err pulse each, busy stays 0, seq_valid stays 0.
- Busy protection: start again mid-run with a different pattern and pat_len=0 → output still matches the original run, no err.
- Reset mid-run: assert rst asynchronously (off clock edge) during the second bit → all outputs are 0 immediately. After release, a new start behaves as in the single-instance scenario.
